// File: rtl/fact_pkg.sv
// Shared definitions for the iterative factorial engine: widths, overflow bound
// and the control FSM state encoding.
package fact_pkg;

  localparam int IN_W  = 4;
  localparam int OUT_W = 32;
  localparam int MAX_N = 12;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    MULT = 2'b10,
    DONE = 2'b11
  } state_e;

endpackage

// File: rtl/fact_mul.sv
// Combinational accumulator-by-operand multiply; only the low OUT_W product bits
// are kept, so overflowing factorials wrap modulo 2^OUT_W.
module fact_mul
  import fact_pkg::*;
(
  input  logic [OUT_W-1:0] a_i,
  input  logic [IN_W-1:0]  b_i,
  output logic [OUT_W-1:0] p_o
);

  assign p_o = a_i * OUT_W'(b_i);

endmodule

// File: rtl/factorial.sv
// Iterative factorial engine: latches n on start, multiplies the accumulator down
// from n to 2, then presents n! on result with a one-cycle Done strobe.
module factorial
  import fact_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [IN_W-1:0]  in,
  output logic             Done,
  output logic             Error,
  output logic [1:0]       CS,
  output logic [OUT_W-1:0] result
);

  localparam logic [IN_W-1:0]  MAX_N_V = IN_W'(MAX_N);
  localparam logic [IN_W-1:0]  ONE_N   = IN_W'(1);
  localparam logic [OUT_W-1:0] ONE_ACC = OUT_W'(1);

  state_e           state_q, state_d;
  logic [IN_W-1:0]  cnt_q, cnt_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0] result_q, result_d;
  logic             err_q, err_d;
  logic [OUT_W-1:0] prod;

  fact_mul u_mul (
    .a_i (acc_q),
    .b_i (cnt_q),
    .p_o (prod)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (go) state_d = LOAD;
      LOAD:    state_d = MULT;
      MULT:    if (cnt_q <= ONE_N) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    Done = (state_q == DONE);
    CS   = state_q;
  end

  // Datapath: cnt counts down to 1 while acc accumulates the running product.
  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      LOAD: begin
        cnt_d = in;
        acc_d = ONE_ACC;
        err_d = (in > MAX_N_V);
      end
      MULT: begin
        if (cnt_q > ONE_N) begin
          acc_d = prod;
          cnt_d = cnt_q - ONE_N;
        end else begin
          result_d = acc_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      acc_q    <= ONE_ACC;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign result = result_q;
  assign Error  = err_q;

endmodule

// File: tb/tb_factorial.sv
// Directed bench for the factorial engine: expected result/Error pairs are queued
// at start time and retired by a monitor whenever Done is seen.
module tb_factorial;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        go  = 1'b0;
  logic [3:0]  in  = 4'd0;
  logic        Done;
  logic        Error;
  logic [1:0]  CS;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  factorial dut (
    .clk    (clk),
    .rst    (rst),
    .go     (go),
    .in     (in),
    .Done   (Done),
    .Error  (Error),
    .CS     (CS),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fact(input int n);
    longint unsigned r = 1;
    for (int i = 2; i <= n; i++) r = (r * longint'(i)) & 64'hFFFF_FFFF;
    return r[31:0];
  endfunction

  task automatic push(input int n);
    exp_t e;
    e.res = fact(n);
    e.err = (n > 12);
    sb.push_back(e);
  endtask

  // Scoreboard retirement on every Done strobe.
  always @(negedge clk) begin
    if (rst && Done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", {31'd0, Done}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("error", {31'd0, Error}, {31'd0, e.err});
      end
    end
  end

  // One standalone computation started on a falling edge; optionally disturbs in during MULT.
  task automatic run(input int n, input bit chg);
    int edges;
    logic [3:0] nv;
    nv = n[3:0];
    in = nv;
    go = 1'b1;
    push(n);
    @(negedge clk);
    go = 1'b0;
    edges = 1;
    chk("load_state", {30'd0, CS}, 32'd1);
    while (!Done && edges < 40) begin
      if (chg && edges == 2) in = ~nv;
      @(negedge clk);
      edges++;
    end
    chk($sformatf("latency_n%0d", n), edges, (n < 2) ? 3 : n + 2);
    @(negedge clk);
    chk("back_to_idle", {30'd0, CS}, 32'd0);
  endtask

  initial begin
    int cnt;
    logic [1:0] cs_seq [6];
    cs_seq = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b11, 2'b00};

    // T1: reset values, then idle with go low
    repeat (2) @(negedge clk);
    chk("rst_cs", {30'd0, CS}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_done", {31'd0, Done}, 32'd0);
    chk("rst_error", {31'd0, Error}, 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_hold", {30'd0, CS}, 32'd0);

    // T2: n=3 state trace and Done timing
    in = 4'd3;
    go = 1'b1;
    push(3);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      go = 1'b0;
      chk($sformatf("t2_cs_%0d", k + 1), {30'd0, CS}, {30'd0, cs_seq[k]});
      chk($sformatf("t2_done_%0d", k + 1), {31'd0, Done}, (k == 4) ? 32'd1 : 32'd0);
    end

    // T3: go held high, back-to-back runs 4..12
    in = 4'd4;
    go = 1'b1;
    push(4);
    for (int n = 4; n <= 12; n++) begin
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (!Done && cnt < 40);
      chk($sformatf("t3_gap_n%0d", n), cnt, (n == 4) ? n + 2 : n + 3);
      if (n < 12) begin
        in = 4'(n + 1);
        push(n + 1);
      end else begin
        go = 1'b0;
      end
    end
    @(negedge clk);
    chk("t3_idle", {30'd0, CS}, 32'd0);

    // T4: overflow operands
    run(13, 1'b0);
    chk("t4_error_held", {31'd0, Error}, 32'd1);
    run(14, 1'b0);

    // T5: trivial operands and operand change during MULT
    run(0, 1'b0);
    run(1, 1'b0);
    run(6, 1'b1);

    // T6: reset in the middle of a long computation
    in = 4'd10;
    go = 1'b1;
    push(10);
    @(negedge clk);
    go = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_in_mult", {30'd0, CS}, 32'd2);
    rst = 1'b0;
    void'(sb.pop_back());
    #1;
    chk("t6_abort_cs", {30'd0, CS}, 32'd0);
    chk("t6_abort_result", result, 32'd0);
    chk("t6_abort_done", {31'd0, Done}, 32'd0);
    chk("t6_abort_error", {31'd0, Error}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (15) @(negedge clk);
    chk("t6_still_idle", {30'd0, CS}, 32'd0);
    run(5, 1'b0);

    repeat (2) @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
